ip_periph_ctrl: RTL and testbench

- Parametrised successor of the LSU input-peripheral memory.
- Samples switch and button inputs through synchronisers and a tick-based debouncer.
- Exposes debounced values plus sticky change/press flags as LSU-readable registers in the input-peripheral window. Flags are write-1-to-clear; an optional button interrupt is provided.
- Read data is registered and byte/half/word extracted with sign or zero extension, replacing the fixed word-only extractor.

---
 rtl/ip_periph_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ip_periph_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ip_periph_ctrl.sv
// ip_periph_ctrl
//   LSU-mapped input peripheral: switches and push-buttons are synchronised,
//   debounced on a slow sample tick, and exposed in a 32-byte register window
//   together with sticky write-1-to-clear change/press flags and a button
//   interrupt.
//
//   Register window (word offset from BASE_ADDR):
//     0x00 SW         debounced switches (RO)
//     0x04 SW_CHG     sticky per-bit change flags (W1C)
//     0x10 BTN        debounced buttons (RO)
//     0x14 BTN_PRESS  sticky per-bit debounced rising-edge flags (W1C)
//     0x18 IRQ_EN     button interrupt enables (RW)
//     others          read 0, writes ignored
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_lsu_addr         LSU byte address
//   i_lsu_rden         load request
//   i_lsu_wren         store request
//   i_st_data          lane-aligned store data
//   i_num_byte         access size: 0001 byte, 0011 half, 1111 word
//   i_sig_uns          1 = zero-extend loads, 0 = sign-extend
//   i_io_sw, i_io_btn  raw asynchronous inputs
//   o_ip_data          registered load data (0 when no hit)
//   o_ip_hit           registered: previous-cycle load hit this window
//   o_btn_irq          level interrupt, |(BTN_PRESS & IRQ_EN)
module ip_periph_ctrl #(
    parameter int          SW_W       = 32,
    parameter int          BTN_W      = 4,
    parameter int          DEB_CYCLES = 1000,
    parameter logic [15:0] BASE_ADDR  = 16'h7800
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_lsu_addr,
    input  logic             i_lsu_rden,
    input  logic             i_lsu_wren,
    input  logic [31:0]      i_st_data,
    input  logic [3:0]       i_num_byte,
    input  logic             i_sig_uns,
    input  logic [SW_W-1:0]  i_io_sw,
    input  logic [BTN_W-1:0] i_io_btn,
    output logic [31:0]      o_ip_data,
    output logic             o_ip_hit,
    output logic             o_btn_irq
);

    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    // ---------------- state ----------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW_W-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [SW_W-1:0]  sw_h1_q, sw_h1_d, sw_h2_q, sw_h2_d;
    logic [SW_W-1:0]  sw_deb_q, sw_deb_d, sw_chg_q, sw_chg_d;
    logic [BTN_W-1:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic [BTN_W-1:0] btn_h1_q, btn_h1_d, btn_h2_q, btn_h2_d;
    logic [BTN_W-1:0] btn_deb_q, btn_deb_d, btn_press_q, btn_press_d;
    logic [BTN_W-1:0] irq_en_q, irq_en_d;
    logic [31:0]      ip_data_q, ip_data_d;
    logic             ip_hit_q, ip_hit_d;
    logic             btn_irq_q, btn_irq_d;

    // ---------------- combinational ----------------
    logic             hit, tick, wr;
    logic [2:0]       sel;
    logic [3:0]       be;
    logic [31:0]      wmask, st_m, rword, ext;
    logic [SW_W-1:0]  sw_upd, sw_clr;
    logic [BTN_W-1:0] btn_upd, btn_clr;
    logic [7:0]       rbyte;
    logic [15:0]      rhalf;
    logic [15:0]      unused_addr;

    assign unused_addr = i_lsu_addr[31:16];

    always_comb begin
        hit  = (i_lsu_addr[15:5] == BASE_ADDR[15:5]);
        sel  = i_lsu_addr[4:2];
        tick = (cnt_q == CNT_W'(DEB_CYCLES - 1));
        wr   = i_lsu_wren & hit;

        // Byte-lane enables from access size shifted to the byte offset;
        // lanes pushed past bit 3 simply fall off.
        be = i_num_byte << i_lsu_addr[1:0];
        for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{be[i]}};
        st_m = i_st_data & wmask;

        // Tick counter and synchronisers.
        cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
        sw_s1_d  = i_io_sw;
        sw_s2_d  = sw_s1_q;
        btn_s1_d = i_io_btn;
        btn_s2_d = btn_s1_q;

        // Sample history shifts on the tick only.
        sw_h1_d  = tick ? sw_s2_q  : sw_h1_q;
        sw_h2_d  = tick ? sw_h1_q  : sw_h2_q;
        btn_h1_d = tick ? btn_s2_q : btn_h1_q;
        btn_h2_d = tick ? btn_h1_q : btn_h2_q;

        // A bit flips when three consecutive samples agree and differ from
        // the current debounced value (uses pre-shift history).
        sw_upd  = tick ? (~(sw_s2_q ^ sw_h1_q) & ~(sw_h1_q ^ sw_h2_q)
                          & (sw_s2_q ^ sw_deb_q)) : '0;
        btn_upd = tick ? (~(btn_s2_q ^ btn_h1_q) & ~(btn_h1_q ^ btn_h2_q)
                          & (btn_s2_q ^ btn_deb_q)) : '0;
        sw_deb_d  = sw_deb_q ^ sw_upd;
        btn_deb_d = btn_deb_q ^ btn_upd;

        // Sticky flags: a set on the same edge as a W1C wins.
        sw_clr   = (wr && sel == 3'd1) ? st_m[SW_W-1:0]  : '0;
        btn_clr  = (wr && sel == 3'd5) ? st_m[BTN_W-1:0] : '0;
        sw_chg_d    = (sw_chg_q & ~sw_clr) | sw_upd;
        btn_press_d = (btn_press_q & ~btn_clr) | (btn_upd & btn_s2_q);

        irq_en_d = irq_en_q;
        if (wr && sel == 3'd6)
            irq_en_d = (irq_en_q & ~wmask[BTN_W-1:0]) | st_m[BTN_W-1:0];

        btn_irq_d = |(btn_press_q & irq_en_q);

        // Read path from current (pre-write) register values.
        rword = '0;
        case (sel)
            3'd0: rword[SW_W-1:0]  = sw_deb_q;
            3'd1: rword[SW_W-1:0]  = sw_chg_q;
            3'd4: rword[BTN_W-1:0] = btn_deb_q;
            3'd5: rword[BTN_W-1:0] = btn_press_q;
            3'd6: rword[BTN_W-1:0] = irq_en_q;
            default: rword = '0;
        endcase

        case (i_lsu_addr[1:0])
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf = i_lsu_addr[1] ? rword[31:16] : rword[15:0];

        case (i_num_byte)
            4'b0001: ext = {{24{~i_sig_uns & rbyte[7]}}, rbyte};
            4'b0011: ext = {{16{~i_sig_uns & rhalf[15]}}, rhalf};
            4'b1111: ext = rword;
            default: ext = '0;
        endcase

        ip_hit_d  = i_lsu_rden & hit;
        ip_data_d = ip_hit_d ? ext : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q       <= '0;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            sw_h1_q     <= '0;
            sw_h2_q     <= '0;
            sw_deb_q    <= '0;
            sw_chg_q    <= '0;
            btn_s1_q    <= '0;
            btn_s2_q    <= '0;
            btn_h1_q    <= '0;
            btn_h2_q    <= '0;
            btn_deb_q   <= '0;
            btn_press_q <= '0;
            irq_en_q    <= '0;
            ip_data_q   <= '0;
            ip_hit_q    <= 1'b0;
            btn_irq_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sw_s1_q     <= sw_s1_d;
            sw_s2_q     <= sw_s2_d;
            sw_h1_q     <= sw_h1_d;
            sw_h2_q     <= sw_h2_d;
            sw_deb_q    <= sw_deb_d;
            sw_chg_q    <= sw_chg_d;
            btn_s1_q    <= btn_s1_d;
            btn_s2_q    <= btn_s2_d;
            btn_h1_q    <= btn_h1_d;
            btn_h2_q    <= btn_h2_d;
            btn_deb_q   <= btn_deb_d;
            btn_press_q <= btn_press_d;
            irq_en_q    <= irq_en_d;
            ip_data_q   <= ip_data_d;
            ip_hit_q    <= ip_hit_d;
            btn_irq_q   <= btn_irq_d;
        end
    end

    assign o_ip_data = ip_data_q;
    assign o_ip_hit  = ip_hit_q;
    assign o_btn_irq = btn_irq_q;

endmodule

// File: tb/tb_ip_periph_ctrl.sv
module tb_ip_periph_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic        rden = 1'b0;
    logic        wren = 1'b0;
    logic [31:0] st_data = '0;
    logic [3:0]  num_byte = 4'b1111;
    logic        sig_uns = 1'b0;
    logic [31:0] io_sw = '0;
    logic [3:0]  io_btn = '0;
    logic [31:0] ip_data;
    logic        ip_hit;
    logic        btn_irq;

    int total  = 0;
    int passed = 0;

    ip_periph_ctrl #(
        .SW_W(32), .BTN_W(4), .DEB_CYCLES(4), .BASE_ADDR(16'h7800)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_lsu_addr(addr), .i_lsu_rden(rden),
        .i_lsu_wren(wren), .i_st_data(st_data), .i_num_byte(num_byte),
        .i_sig_uns(sig_uns), .i_io_sw(io_sw), .i_io_btn(io_btn),
        .o_ip_data(ip_data), .o_ip_hit(ip_hit), .o_btn_irq(btn_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Read issued for one edge; outputs sampled on the following negedge.
    task automatic rd(input logic [31:0] a, input logic [3:0] nb, input logic uns);
        @(negedge clk);
        addr = a; num_byte = nb; sig_uns = uns; rden = 1'b1;
        @(negedge clk);
        rden = 1'b0; num_byte = 4'b1111; sig_uns = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        rd(a, 4'b1111, 1'b0);
        check({tag, "_hit"}, {31'd0, ip_hit}, 32'd1);
        check(tag, ip_data, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; st_data = d; num_byte = 4'b1111; wren = 1'b1;
        @(negedge clk);
        wren = 1'b0;
    endtask

    initial begin
        bit saw_irq;

        // Reset state
        rst = 1'b1;
        cycles(3);
        check("rst_data", ip_data, 32'h0);
        check("rst_hit", {31'd0, ip_hit}, 32'd0);
        check("rst_irq", {31'd0, btn_irq}, 32'd0);
        @(negedge clk) rst = 1'b0;
        rd_chk("sw_after_rst", 32'h7800, 32'h0);
        check("irq_after_rst", {31'd0, btn_irq}, 32'd0);

        // Switch debounce and change flags
        io_sw = 32'hA5A5_00FF;
        cycles(20);
        rd_chk("sw_val", 32'h7800, 32'hA5A5_00FF);
        rd_chk("sw_chg", 32'h7804, 32'hA5A5_00FF);
        wr(32'h7804, 32'h0000_00FF);
        rd_chk("sw_chg_w1c", 32'h7804, 32'hA5A5_0000);

        // Short button pulse is filtered
        io_btn = 4'h4;
        cycles(3);
        io_btn = 4'h0;
        cycles(20);
        rd_chk("btn_glitch", 32'h7810, 32'h0);
        rd_chk("press_glitch", 32'h7814, 32'h0);

        // Long press is reflected
        io_btn = 4'h4;
        cycles(20);
        rd_chk("btn_held", 32'h7810, 32'h4);
        rd_chk("press_held", 32'h7814, 32'h4);
        check("irq_disabled", {31'd0, btn_irq}, 32'd0);

        // Clear, release, then enable interrupt and press again
        wr(32'h7814, 32'h4);
        io_btn = 4'h0;
        cycles(20);
        rd_chk("press_after_rel", 32'h7814, 32'h0);
        wr(32'h7818, 32'hFFFF_FFF4);
        rd_chk("irq_en", 32'h7818, 32'h4);
        check("irq_before_press", {31'd0, btn_irq}, 32'd0);
        io_btn = 4'h4;
        cycles(20);
        check("irq_on_press", {31'd0, btn_irq}, 32'd1);
        wr(32'h7814, 32'h4);
        check("irq_w1c_edge", {31'd0, btn_irq}, 32'd1);
        cycles(1);
        check("irq_w1c_next", {31'd0, btn_irq}, 32'd0);

        // W1C held every cycle across a new press: the set edge must win,
        // which makes the interrupt pulse for one cycle.
        io_btn = 4'h0;
        cycles(20);
        @(negedge clk);
        addr = 32'h7814; st_data = 32'h4; num_byte = 4'b1111; wren = 1'b1;
        io_btn = 4'h4;
        saw_irq = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (btn_irq) saw_irq = 1'b1;
        end
        wren = 1'b0;
        check("set_beats_w1c", {31'd0, saw_irq}, 32'd1);
        rd_chk("btn_after_w1c", 32'h7810, 32'h4);

        // Load extraction
        io_sw = 32'h0000_8080;
        cycles(20);
        rd_chk("sw_word", 32'h7800, 32'h0000_8080);
        rd(32'h7800, 4'b0001, 1'b0);
        check("byte_signed", ip_data, 32'hFFFF_FF80);
        rd(32'h7800, 4'b0001, 1'b1);
        check("byte_unsigned", ip_data, 32'h0000_0080);
        rd(32'h7801, 4'b0001, 1'b0);
        check("byte1_signed", ip_data, 32'hFFFF_FF80);
        rd(32'h7802, 4'b0011, 1'b0);
        check("half_hi_signed", ip_data, 32'h0000_0000);
        rd(32'h7800, 4'b0011, 1'b0);
        check("half_lo_signed", ip_data, 32'hFFFF_8080);
        rd(32'h7800, 4'b0011, 1'b1);
        check("half_lo_unsigned", ip_data, 32'h0000_8080);
        rd(32'h7800, 4'b0111, 1'b0);
        check("bad_size", ip_data, 32'h0);
        check("bad_size_hit", {31'd0, ip_hit}, 32'd1);

        // Unmapped offset and miss
        rd_chk("unmapped_off", 32'h7808, 32'h0);
        rd(32'h7820, 4'b1111, 1'b0);
        check("miss_hit", {31'd0, ip_hit}, 32'd0);
        check("miss_data", ip_data, 32'h0);

        // Reset in the middle of a debounce
        io_sw = 32'h0000_0001;
        cycles(5);
        rst = 1'b1;
        cycles(2);
        check("rst2_irq", {31'd0, btn_irq}, 32'd0);
        rst = 1'b0;
        rd_chk("sw_post_rst", 32'h7800, 32'h0);
        cycles(13);
        rd_chk("sw_resettled", 32'h7800, 32'h1);
        rd_chk("chg_resettled", 32'h7804, 32'h1);
        rd_chk("irq_en_cleared", 32'h7818, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
